// File: rtl/pattern_serializer_if.sv
// Bus bundle for pattern_serializer: request side (start/pattern/repeat)
// plus the serial line and its status outputs. Names are from the
// serializer's point of view (_i driven into it, _o driven by it).
interface pattern_serializer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             start_i;
  logic [WIDTH-1:0] pattern_i;
  logic [CNT_W-1:0] rep_i;
  logic             a_o;
  logic             valid_o;
  logic             busy_o;
  logic             done_o;
  logic [1:0]       state_o;

  // Requester / observer side (bench or board controller)
  modport master (
    output start_i, pattern_i, rep_i,
    input  a_o, valid_o, busy_o, done_o, state_o
  );

  // Serializer side
  modport slave (
    input  start_i, pattern_i, rep_i,
    output a_o, valid_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/pattern_serializer.sv
// pattern_serializer: sends a latched WIDTH-bit pattern MSB first, one bit
// per clock, REPEAT+1 times back to back, then pulses DONE for one cycle.
// Every output is a flop loaded from the next-state values, so outputs
// change exactly with the state and no input reaches an output
// combinationally.
module pattern_serializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  pattern_serializer_if.slave   bus
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] rep_q,   rep_d;
  logic             a_q,     a_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Next-state logic: accept a request in IDLE, walk the bits in SHIFT,
  // reload the pattern at each pass boundary while repetitions remain.
  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          latch_d = bus.pattern_i;
          shift_d = bus.pattern_i;
          rep_d   = bus.rep_i;
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (idx_q == LAST_IDX) begin
          // Last bit of this pass: either start the next pass with no gap
          // or finish. The counter is only decremented when non-zero.
          if (rep_q != {CNT_W{1'b0}}) begin
            shift_d = latch_q;
            idx_d   = {IDX_W{1'b0}};
            rep_d   = rep_q - CNT_W'(1);
            state_d = ST_SHIFT;
          end else begin
            shift_d = shift_q << 1;
            state_d = ST_FIN;
          end
        end else begin
          shift_d = shift_q << 1;
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        // Unused encoding recovers to IDLE on the next clock.
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, so the output flops track the
  // state register cycle for cycle.
  always_comb begin
    a_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      ST_SHIFT: begin
        a_d     = shift_d[WIDTH-1];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_FIN: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end
      default: begin
        a_d     = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any stream silently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      latch_q <= {WIDTH{1'b0}};
      shift_q <= {WIDTH{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      rep_q   <= {CNT_W{1'b0}};
      a_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a_o     = a_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: directed and random streams compared
// against a bit-list model built from the pattern and repeat count.
module tb_pattern_serializer;

  localparam int W = 4;
  localparam int C = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pattern_serializer_if #(.WIDTH(W), .CNT_W(C)) bus ();

  pattern_serializer #(.WIDTH(W), .CNT_W(C)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit k of a stream is pattern bit (W-1 - k mod W).
  function automatic logic exp_bit(input logic [W-1:0] p, input int k);
    logic [W-1:0] tmp;
    tmp = p;
    return tmp[W-1 - (k % W)];
  endfunction

  // Present a one-cycle START; returns at the negedge of the first bit cycle.
  task automatic start_stream(input logic [W-1:0] p, input logic [C-1:0] r);
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.pattern_i = p;
    bus.rep_i     = r;
    @(negedge clk);
    bus.start_i   = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.a_o, bus.valid_o, bus.busy_o, bus.done_o, bus.state_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_in: outputs=%b required=000000",
               {bus.a_o, bus.valid_o, bus.busy_o, bus.done_o, bus.state_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.a_o, bus.valid_o, bus.busy_o, bus.done_o, bus.state_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_after: outputs=%b required=000000",
               {bus.a_o, bus.valid_o, bus.busy_o, bus.done_o, bus.state_o});
    end
  endtask

  // Directed cases (single pass, repeat, max repeat) plus random ones.
  task automatic test_streams();
    logic [W-1:0] pats [0:10];
    logic [C-1:0] reps [0:10];
    pats[0] = 4'b1010; reps[0] = 4'd0;
    pats[1] = 4'b1101; reps[1] = 4'd2;
    pats[2] = 4'b1000; reps[2] = 4'hF;
    for (int i = 3; i < 11; i++) begin
      pats[i] = W'($urandom_range(0, 15));
      reps[i] = C'($urandom_range(0, 5));
    end
    for (int i = 0; i < 11; i++) begin
      int n;
      n = W * (int'(reps[i]) + 1);
      start_stream(pats[i], reps[i]);
      // Scramble inputs after acceptance; they must have no effect.
      bus.pattern_i = ~pats[i];
      bus.rep_i     = C'($urandom_range(0, 15));
      for (int k = 0; k < n; k++) begin
        checks++;
        if (bus.a_o !== exp_bit(pats[i], k) || bus.valid_o !== 1'b1 ||
            bus.busy_o !== 1'b1 || bus.done_o !== 1'b0 || bus.state_o !== 2'd1) begin
          failures++;
          $display("FAIL stream case=%0d bit=%0d: a/v/b/d/st=%b%b%b%b/%0d required=%b1110/1",
                   i, k, bus.a_o, bus.valid_o, bus.busy_o, bus.done_o, bus.state_o,
                   exp_bit(pats[i], k));
        end
        @(negedge clk);
      end
      checks++;
      if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.valid_o !== 1'b0 ||
          bus.a_o !== 1'b0 || bus.state_o !== 2'd2) begin
        failures++;
        $display("FAIL fin case=%0d: a/v/b/d/st=%b%b%b%b/%0d required=0011/2",
                 i, bus.a_o, bus.valid_o, bus.busy_o, bus.done_o, bus.state_o);
      end
      @(negedge clk);
      checks++;
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 ||
          bus.state_o !== 2'd0) begin
        failures++;
        $display("FAIL idle case=%0d: v/b/d/st=%b%b%b/%0d required=000/0",
                 i, bus.valid_o, bus.busy_o, bus.done_o, bus.state_o);
      end
    end
  endtask

  // A second START with a new pattern during a stream is ignored.
  task automatic test_ignored();
    int dones;
    int valids;
    dones  = 0;
    valids = 0;
    start_stream(4'b1011, 4'd1);
    for (int c = 0; c < 16; c++) begin
      if (c < 8) begin
        checks++;
        if (bus.a_o !== exp_bit(4'b1011, c) || bus.valid_o !== 1'b1) begin
          failures++;
          $display("FAIL ignored bit=%0d: a/v=%b%b required=%b1",
                   c, bus.a_o, bus.valid_o, exp_bit(4'b1011, c));
        end
      end
      if (bus.done_o === 1'b1) dones++;
      if (bus.valid_o === 1'b1) valids++;
      bus.start_i   = (c == 1) ? 1'b1 : 1'b0;
      bus.pattern_i = 4'b0000;
      @(negedge clk);
    end
    checks++;
    if (dones != 1 || valids != 8) begin
      failures++;
      $display("FAIL ignored_count: dones=%0d valids=%0d required 1 and 8", dones, valids);
    end
  endtask

  // Asynchronous reset mid-stream clears outputs at once, no DONE follows.
  task automatic test_midreset();
    int dones;
    dones = 0;
    start_stream(4'b1110, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.a_o, bus.valid_o, bus.busy_o, bus.done_o, bus.state_o} !== 6'b0) begin
      failures++;
      $display("FAIL midreset: outputs=%b required=000000",
               {bus.a_o, bus.valid_o, bus.busy_o, bus.done_o, bus.state_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus.done_o === 1'b1 || bus.valid_o === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL midreset_quiet: activity cycles=%0d required=0", dones);
    end
    start_stream(4'b0110, 4'd0);
    for (int k = 0; k < W; k++) begin
      checks++;
      if (bus.a_o !== exp_bit(4'b0110, k) || bus.valid_o !== 1'b1) begin
        failures++;
        $display("FAIL post_reset bit=%0d: a/v=%b%b required=%b1",
                 k, bus.a_o, bus.valid_o, exp_bit(4'b0110, k));
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done_o !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_done: done=%b required=1", bus.done_o);
    end
    @(negedge clk);
  endtask

  // START held high: period W+2, bits then FIN then IDLE.
  task automatic test_held();
    logic [W-1:0] p;
    p = W'($urandom_range(0, 15));
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.pattern_i = p;
    bus.rep_i     = 4'd0;
    for (int c = 1; c <= 3 * (W + 2); c++) begin
      int  m;
      logic ea, ev, ed;
      @(negedge clk);
      m  = (c - 1) % (W + 2);
      ev = (m < W);
      ea = ev ? exp_bit(p, m) : 1'b0;
      ed = (m == W);
      checks++;
      if (bus.a_o !== ea || bus.valid_o !== ev || bus.done_o !== ed) begin
        failures++;
        $display("FAIL held cycle=%0d: a/v/d=%b%b%b required=%b%b%b",
                 c, bus.a_o, bus.valid_o, bus.done_o, ea, ev, ed);
      end
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state_o !== 2'd0 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL held_stop: st/v=%0d/%b required=0/0", bus.state_o, bus.valid_o);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.start_i   = 1'b0;
    bus.pattern_i = '0;
    bus.rep_i     = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_streams();
    test_ignored();
    test_midreset();
    test_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Transmit-side companion to the lab's serial sequence detector: it accepts a parallel bit pattern and a repeat count, then drives the pattern out one bit per clock, MSB first, on a serial line. The serial line connects directly to a detector's serial input. The block generates stimulus streams on the board and in benches, and reports progress through BUSY/DONE and a 2-bit state output for LED/display debug.

## Interface
- WIDTH, 4, pattern length in bits (≥2)
- CNT_W, 4, width of repeat-count field
- CLK  input  1  system clock; all state changes on posedge
- RST_N  input  1  asynchronous, active-low reset
- START  input  1  request to begin transmission; sampled only in IDLE
- PATTERN  input  WIDTH  pattern to send; latched on accepted START
- REPEAT  input  CNT_W  extra repetitions; total passes = REPEAT+1; latched on accepted START
- A  output  1  serial data out, MSB of pattern first
- VALID  output  1  high while A carries a pattern bit
- BUSY  output  1  high from first bit through DONE cycle
- DONE  output  1  one-cycle pulse after last bit
- stateOut  output  2  current state encoding (IDLE=0, SHIFT=1, FIN=2)

One clock domain. Reset is asynchronous and active-low.

## Operation
- Registers:
  - WIDTH-bit pattern latch
  - WIDTH-bit shift register
  - bit index counter, clog2(WIDTH) bits
  - CNT_W-bit repetition counter
  - state register
- All outputs decode from registers only (Moore). There is no combinational path from any input to any output.
- IDLE:
  - A=0, VALID=0, BUSY=0, DONE=0.
  - If START=1: latch PATTERN into the latch and the shift register, load REPEAT into the rep counter, clear the bit index, and go to SHIFT.
- SHIFT:
  - A = shift register MSB, VALID=1, BUSY=1.
  - Each cycle: shift left by one and increment the bit index.
  - When the bit index is WIDTH-1 and the rep counter is ≠0: reload the shift register from the latch, clear the bit index, decrement the rep counter, and stay in SHIFT. There is no gap between passes.
  - When the bit index is WIDTH-1 and the rep counter is 0: go to FIN.
- FIN: DONE=1, BUSY=1, VALID=0, A=0. Go unconditionally to IDLE.
- The unused state encoding (3) goes to IDLE on the next clock.
- START outside IDLE is ignored, including START held high. Changes to PATTERN/REPEAT after acceptance have no effect.
- Reset:
  - RST_N=0 at any time, including mid-stream, immediately forces IDLE.
  - All registers clear to 0.
  - Outputs go to A=0, VALID=0, BUSY=0, DONE=0, stateOut=0.
  - No DONE is emitted for an aborted stream.

## Timing
- START sampled high at edge t (state IDLE):
  - bit k (k=0..N-1) is on A during cycle t+1+k, where N = WIDTH·(REPEAT+1)
  - VALID is high for exactly N cycles
- DONE is high during cycle t+N+1, and the state is IDLE from t+N+2.
- Earliest next accepted START is at edge t+N+2. Back-to-back streams with START held high have a 2-cycle gap (FIN plus IDLE) between the last bit and the next first bit.
- BUSY is high for N+1 cycles. stateOut changes in the same cycles as the state.
- Latency from START to first bit: 1 cycle.
- REPEAT=2^CNT_W−1 (maximum) gives N = WIDTH·2^CNT_W. The counter must not wrap or underflow.
- Reset release: the first START can be accepted on the first posedge after RST_N rises.

## Test plan
- **Single pass:** WIDTH=4, PATTERN=4'b1010, REPEAT=0, START pulsed at t -> A=1,0,1,0 in t+1..t+4, VALID high for those 4 cycles, DONE in t+5 only, stateOut 1,1,1,1,2,0. When A is fed to the detector, its Z is high in cycle t+4.
- **Repeat:** PATTERN=4'b1101, REPEAT=2 -> 12 contiguous bits 1101 1101 1101 in t+1..t+12, DONE in t+13, no VALID gap at the pass boundaries.
- **Ignored inputs:** START pulsed again at t+2 with PATTERN changed to 4'b0000 -> output stream unchanged from the first pattern, no second stream begins, DONE count = 1.
- **Mid-stream reset:** RST_N low asynchronously during bit 2 -> A, VALID, BUSY and DONE are 0 and stateOut=0 before the next edge. No DONE follows. A new START after release yields a full, correct stream.
- **START held high:** REPEAT=0 -> streams repeat with the first bit at t+1 and t+7 (period N+2=6), and DONE pulses once per stream.
- **Maximum repeat:** REPEAT=4'hF, PATTERN=4'b1000 -> 64 bits, with a 1 every 4th bit starting at t+1, DONE at t+65, no early termination.
